// File: rtl/mrd_pkg.sv
// Shared definitions for the multi-stage read/write frame controller:
// state encoding, default wait length and stage-count normalisation.
package mrd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SINK        = 3'd1,
    ST_WAIT_TO_RD  = 3'd2,
    ST_RD          = 3'd3,
    ST_WAIT_WR_END = 3'd4,
    ST_SOURCE      = 3'd5
  } state_e;

  localparam int WAIT_CYC_DEF = 4;

  // A stage count of zero still means one pass through the butterfly.
  function automatic logic [2:0] effStages(input logic [2:0] n);
    return (n == 3'd0) ? 3'd1 : n;
  endfunction

endpackage

// File: rtl/mrd_fsm_ctrl.sv
// Frame controller: sinks a frame, runs num_stages read/write-back passes,
// then streams N beats out. All outputs are registered.
module mrd_fsm_ctrl
  import mrd_pkg::*;
#(
  parameter int wCNT     = 12,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [wCNT-1:0] dft_size,
  input  logic [2:0]      num_stages,
  input  logic            in_valid,
  input  logic            in_sop,
  input  logic            in_eop,
  input  logic            overTime,
  input  logic            rd_last,
  input  logic            wr_last,
  input  logic            src_ready,
  output logic            in_ready,
  output logic [2:0]      fsm,
  output logic [2:0]      stage,
  output logic            rd_start,
  output logic            src_valid,
  output logic            src_last,
  output logic            done,
  output logic            err_overtime,
  output logic            err_len
);

  localparam logic [wCNT-1:0] CNT_MAX   = '1;
  localparam logic [wCNT-1:0] WAIT_LAST = (WAIT_CYC > 1) ? wCNT'(WAIT_CYC - 1) : '0;

  state_e          r_state, w_stateNxt;
  logic [2:0]      r_stage, w_stageNxt;
  logic [2:0]      r_nStg, w_nStgNxt;
  logic [wCNT-1:0] r_cnt, w_cntNxt;
  logic [wCNT-1:0] r_wait, w_waitNxt;
  logic [wCNT-1:0] r_n, w_nNxt;
  logic [wCNT-1:0] w_cntInc;
  logic            r_inReady, r_srcValid, r_srcLast, r_rdStart;
  logic            r_done, r_errOt, r_errLen;
  logic            w_inReadyNxt, w_srcValidNxt, w_srcLastNxt, w_rdStartNxt;
  logic            w_doneNxt, w_errOtNxt, w_errLenNxt;

  assign w_cntInc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + wCNT'(1);

  always_comb begin
    w_stateNxt  = r_state;
    w_stageNxt  = r_stage;
    w_nStgNxt   = r_nStg;
    w_cntNxt    = r_cnt;
    w_waitNxt   = r_wait;
    w_nNxt      = r_n;
    w_doneNxt   = 1'b0;
    w_errOtNxt  = 1'b0;
    w_errLenNxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && in_sop) begin
          w_stateNxt = ST_SINK;
          w_nNxt     = dft_size;
          w_nStgNxt  = effStages(num_stages);
          w_cntNxt   = wCNT'(1);
          w_stageNxt = 3'd0;
        end
      end
      ST_SINK: begin
        // Watchdog abort wins over a coincident end-of-packet.
        if (overTime) begin
          w_stateNxt = ST_IDLE;
          w_errOtNxt = 1'b1;
        end else if (in_valid) begin
          w_cntNxt = w_cntInc;
          if (in_eop) begin
            if (w_cntInc == r_n && w_cntInc != CNT_MAX) begin
              w_stateNxt = ST_WAIT_TO_RD;
              w_stageNxt = 3'd0;
              w_waitNxt  = '0;
            end else begin
              w_stateNxt  = ST_IDLE;
              w_errLenNxt = 1'b1;
            end
          end
        end
      end
      ST_WAIT_TO_RD: begin
        if (r_wait >= WAIT_LAST) begin
          w_stateNxt = ST_RD;
        end else begin
          w_waitNxt = r_wait + wCNT'(1);
        end
      end
      ST_RD: begin
        if (rd_last) begin
          w_stateNxt = ST_WAIT_WR_END;
        end
      end
      ST_WAIT_WR_END: begin
        if (wr_last) begin
          if (r_stage == r_nStg - 3'd1) begin
            w_stateNxt = ST_SOURCE;
            w_cntNxt   = '0;
          end else begin
            w_stateNxt = ST_WAIT_TO_RD;
            w_stageNxt = r_stage + 3'd1;
            w_waitNxt  = '0;
          end
        end
      end
      ST_SOURCE: begin
        if (src_ready) begin
          if (r_cnt == r_n - wCNT'(1)) begin
            w_stateNxt = ST_IDLE;
            w_doneNxt  = 1'b1;
          end else begin
            w_cntNxt = r_cnt + wCNT'(1);
          end
        end
      end
      default: w_stateNxt = ST_IDLE;
    endcase

    if (w_stateNxt == ST_IDLE) begin
      w_stageNxt = 3'd0;
      w_cntNxt   = '0;
      w_waitNxt  = '0;
    end

    w_inReadyNxt  = (w_stateNxt == ST_IDLE) || (w_stateNxt == ST_SINK);
    w_srcValidNxt = (w_stateNxt == ST_SOURCE);
    w_srcLastNxt  = (w_stateNxt == ST_SOURCE) && (w_cntNxt == w_nNxt - wCNT'(1));
    w_rdStartNxt  = (w_stateNxt == ST_RD) && (r_state != ST_RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_stage    <= 3'd0;
      r_nStg     <= 3'd0;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_n        <= '0;
      r_inReady  <= 1'b1;
      r_srcValid <= 1'b0;
      r_srcLast  <= 1'b0;
      r_rdStart  <= 1'b0;
      r_done     <= 1'b0;
      r_errOt    <= 1'b0;
      r_errLen   <= 1'b0;
    end else begin
      r_state    <= w_stateNxt;
      r_stage    <= w_stageNxt;
      r_nStg     <= w_nStgNxt;
      r_cnt      <= w_cntNxt;
      r_wait     <= w_waitNxt;
      r_n        <= w_nNxt;
      r_inReady  <= w_inReadyNxt;
      r_srcValid <= w_srcValidNxt;
      r_srcLast  <= w_srcLastNxt;
      r_rdStart  <= w_rdStartNxt;
      r_done     <= w_doneNxt;
      r_errOt    <= w_errOtNxt;
      r_errLen   <= w_errLenNxt;
    end
  end

  assign fsm          = r_state;
  assign stage        = r_stage;
  assign in_ready     = r_inReady;
  assign src_valid    = r_srcValid;
  assign src_last     = r_srcLast;
  assign rd_start     = r_rdStart;
  assign done         = r_done;
  assign err_overtime = r_errOt;
  assign err_len      = r_errLen;

endmodule

// File: tb/tb_mrd_fsm_ctrl.sv
// Directed bench for mrd_fsm_ctrl: normal frames, length/overtime aborts,
// saturation, source stalls, mid-frame reset and zero-stage frames.
module tb_mrd_fsm_ctrl;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] dft_size = '0;
  logic [2:0]    num_stages = '0;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, overTime = 1'b0;
  logic          rd_last = 1'b0, wr_last = 1'b0, src_ready = 1'b0;
  logic          in_ready, rd_start, src_valid, src_last, done, err_overtime, err_len;
  logic [2:0]    fsm, stage;

  int checks = 0;
  int errors = 0;

  int  rdStartCnt = 0, doneCnt = 0, accCnt = 0, lastAccCnt = 0, lastAccIdx = 0;
  int  errLenCnt = 0, errOtCnt = 0, validDrop = 0;
  time lastAccTime = 0, doneTime = 0;
  logic [2:0] fsmLog[$];
  logic [2:0] prevFsm = 3'bxxx;

  always #5 clk = ~clk;

  mrd_fsm_ctrl #(.wCNT(CW), .WAIT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .dft_size(dft_size), .num_stages(num_stages),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .overTime(overTime),
    .rd_last(rd_last), .wr_last(wr_last), .src_ready(src_ready),
    .in_ready(in_ready), .fsm(fsm), .stage(stage), .rd_start(rd_start),
    .src_valid(src_valid), .src_last(src_last), .done(done),
    .err_overtime(err_overtime), .err_len(err_len)
  );

  // Event monitor sampled mid-cycle; tests compare deltas of these counters.
  always @(negedge clk) begin
    if (fsm !== prevFsm) fsmLog.push_back(fsm);
    prevFsm = fsm;
    if (rd_start === 1'b1) rdStartCnt++;
    if (done === 1'b1) begin doneCnt++; doneTime = $time; end
    if (err_len === 1'b1) errLenCnt++;
    if (err_overtime === 1'b1) errOtCnt++;
    if (fsm === 3'd5 && src_valid !== 1'b1) validDrop++;
    if (src_valid === 1'b1 && src_ready === 1'b1) begin
      if (src_last === 1'b1) begin
        lastAccCnt++;
        lastAccIdx  = accCnt;
        lastAccTime = $time;
      end
      accCnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sinkFrame(input int eopBeat, input bit otOnEop, input bit extraSop);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = (eopBeat == 1); overTime = 1'b0;
    tick();
    for (int b = 2; b <= eopBeat; b++) begin
      in_sop   = extraSop && (b == 5);
      in_eop   = (b == eopBeat);
      overTime = otOnEop && (b == eopBeat);
      tick();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; overTime = 1'b0;
  endtask

  task automatic waitFsm(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fsm === target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic runStages(input int nStg, output bit ok);
    bit w;
    ok = 1'b1;
    for (int s = 0; s < nStg; s++) begin
      waitFsm(3'd3, 40, w);
      if (!w) begin ok = 1'b0; return; end
      repeat (4) tick();
      rd_last = 1'b1; tick(); rd_last = 1'b0;
      waitFsm(3'd4, 10, w);
      if (!w) begin ok = 1'b0; return; end
      repeat (4) tick();
      wr_last = 1'b1; tick(); wr_last = 1'b0;
    end
  endtask

  task automatic runSource(input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      src_ready = toggle ? (i % 2 == 0) : 1'b1;
      tick();
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    src_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    checks++;
    if (fsm !== 3'd0) begin errors++; $display("FAIL reset_fsm: got %0d expected 0", fsm); end
    checks++;
    if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", stage); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if ({src_valid, src_last, rd_start, done, err_overtime, err_len} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {src_valid, src_last, rd_start, done, err_overtime, err_len});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (fsm !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: fsm %0d in_ready %b expected 0/1", fsm, in_ready);
    end
  endtask

  task automatic test_normal();
    int rs0 = rdStartCnt, d0 = doneCnt, a0 = accCnt;
    int logBase = fsmLog.size();
    int expSeq[9] = '{1, 2, 3, 4, 2, 3, 4, 5, 0};
    bit ok, seqBad;
    dft_size = 12; num_stages = 3'd2;
    in_valid = 1'b1; in_sop = 1'b1;
    tick();
    dft_size = 7; num_stages = 3'd5;
    checks++;
    if (fsm !== 3'd1) begin errors++; $display("FAIL normal_sink: fsm %0d expected 1", fsm); end
    for (int b = 2; b <= 12; b++) begin
      in_sop = (b == 5);
      in_eop = (b == 12);
      tick();
    end
    in_eop = 1'b0; in_sop = 1'b1;
    checks++;
    if (fsm !== 3'd2 || stage !== 3'd0) begin
      errors++; $display("FAIL normal_eop: fsm %0d stage %0d expected 2/0", fsm, stage);
    end
    for (int s = 0; s < 2; s++) begin
      repeat (3) tick();
      checks++;
      if (fsm !== 3'd2) begin errors++; $display("FAIL wait_hold s%0d: fsm %0d expected 2", s, fsm); end
      tick();
      checks++;
      if (fsm !== 3'd3 || rd_start !== 1'b1 || stage !== 3'(s) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL rd_entry s%0d: fsm %0d rd_start %b stage %0d in_ready %b expected 3/1/%0d/0",
                 s, fsm, rd_start, stage, in_ready, s);
      end
      wr_last = 1'b1; tick(); wr_last = 1'b0;
      checks++;
      if (fsm !== 3'd3 || rd_start !== 1'b0) begin
        errors++; $display("FAIL rd_hold s%0d: fsm %0d rd_start %b expected 3/0", s, fsm, rd_start);
      end
      repeat (3) tick();
      rd_last = 1'b1; tick(); rd_last = 1'b0;
      checks++;
      if (fsm !== 3'd4) begin errors++; $display("FAIL rd_last s%0d: fsm %0d expected 4", s, fsm); end
      repeat (4) tick();
      wr_last = 1'b1; tick(); wr_last = 1'b0;
      checks++;
      if (fsm !== ((s == 1) ? 3'd5 : 3'd2) || stage !== 3'd1) begin
        errors++;
        $display("FAIL wr_last s%0d: fsm %0d stage %0d expected %0d/1", s, fsm, stage, (s == 1) ? 5 : 2);
      end
    end
    in_valid = 1'b0; in_sop = 1'b0;
    checks++;
    if (src_valid !== 1'b1 || src_last !== 1'b0) begin
      errors++; $display("FAIL source_entry: src_valid %b src_last %b expected 1/0", src_valid, src_last);
    end
    runSource(1'b0, ok);
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL normal_done_timeout: done %b expected 1", done); end
    checks++;
    if (accCnt - a0 != 12 || doneCnt - d0 != 1 || rdStartCnt - rs0 != 2) begin
      errors++;
      $display("FAIL normal_counts: beats %0d done %0d rd_start %0d expected 12/1/2",
               accCnt - a0, doneCnt - d0, rdStartCnt - rs0);
    end
    seqBad = (fsmLog.size() - logBase != 9);
    if (!seqBad)
      for (int i = 0; i < 9; i++) if (int'(fsmLog[logBase + i]) != expSeq[i]) seqBad = 1'b1;
    checks++;
    if (seqBad) begin
      errors++; $display("FAIL normal_fsm_seq: %0d states logged, expected 1,2,3,4,2,3,4,5,0",
                         fsmLog.size() - logBase);
    end
  endtask

  task automatic test_len_err();
    int rs0 = rdStartCnt;
    dft_size = 12; num_stages = 3'd2;
    sinkFrame(10, 1'b0, 1'b0);
    checks++;
    if (fsm !== 3'd0 || err_len !== 1'b1 || err_overtime !== 1'b0) begin
      errors++; $display("FAIL len_short: fsm %0d err_len %b err_ot %b expected 0/1/0", fsm, err_len, err_overtime);
    end
    tick();
    checks++;
    if (err_len !== 1'b0) begin errors++; $display("FAIL len_pulse: err_len %b expected 0", err_len); end
    sinkFrame(13, 1'b0, 1'b0);
    checks++;
    if (fsm !== 3'd0 || err_len !== 1'b1) begin
      errors++; $display("FAIL len_long: fsm %0d err_len %b expected 0/1", fsm, err_len);
    end
    repeat (8) tick();
    checks++;
    if (rdStartCnt != rs0) begin errors++; $display("FAIL len_rd_start: got %0d expected 0", rdStartCnt - rs0); end
  endtask

  task automatic test_overtime();
    int l0 = errLenCnt, o0 = errOtCnt;
    dft_size = 12; num_stages = 3'd1;
    sinkFrame(12, 1'b1, 1'b0);
    checks++;
    if (fsm !== 3'd0 || err_overtime !== 1'b1 || err_len !== 1'b0) begin
      errors++; $display("FAIL overtime: fsm %0d err_ot %b err_len %b expected 0/1/0", fsm, err_overtime, err_len);
    end
    tick();
    checks++;
    if (errOtCnt - o0 != 1 || errLenCnt != l0) begin
      errors++; $display("FAIL overtime_counts: ot %0d len %0d expected 1/0", errOtCnt - o0, errLenCnt - l0);
    end
  endtask

  task automatic test_saturation();
    dft_size = 12'hFFF; num_stages = 3'd1;
    sinkFrame(4095, 1'b0, 1'b0);
    checks++;
    if (fsm !== 3'd0 || err_len !== 1'b1) begin
      errors++; $display("FAIL saturation: fsm %0d err_len %b expected 0/1", fsm, err_len);
    end
    tick();
  endtask

  task automatic test_stall();
    int a0, lc0, vd0;
    bit ok;
    dft_size = 12; num_stages = 3'd1;
    sinkFrame(12, 1'b0, 1'b0);
    runStages(1, ok);
    checks++;
    if (!ok || fsm !== 3'd5) begin errors++; $display("FAIL stall_stages: ok %b fsm %0d expected 1/5", ok, fsm); end
    a0 = accCnt; lc0 = lastAccCnt; vd0 = validDrop;
    runSource(1'b1, ok);
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_done_timeout: done %b expected 1", done); end
    checks++;
    if (accCnt - a0 != 12 || lastAccCnt - lc0 != 1 || lastAccIdx - a0 != 11) begin
      errors++;
      $display("FAIL stall_beats: beats %0d lasts %0d last_idx %0d expected 12/1/11",
               accCnt - a0, lastAccCnt - lc0, lastAccIdx - a0);
    end
    checks++;
    if (doneTime - lastAccTime != 10) begin
      errors++; $display("FAIL stall_done_lag: got %0t expected 10", doneTime - lastAccTime);
    end
    checks++;
    if (validDrop != vd0) begin errors++; $display("FAIL stall_valid_drop: got %0d expected 0", validDrop - vd0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok;
    dft_size = 12; num_stages = 3'd2;
    sinkFrame(12, 1'b0, 1'b0);
    runStages(1, ok);
    waitFsm(3'd3, 20, ok);
    checks++;
    if (!ok || stage !== 3'd1) begin errors++; $display("FAIL mid_rd: ok %b stage %0d expected 1/1", ok, stage); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (fsm !== 3'd0 || stage !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: fsm %0d stage %0d in_ready %b expected 0/0/1", fsm, stage, in_ready);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (fsm !== 3'd0) begin errors++; $display("FAIL mid_need_sop: fsm %0d expected 0", fsm); end
    d0 = doneCnt;
    sinkFrame(12, 1'b0, 1'b0);
    runStages(2, ok);
    runSource(1'b0, ok);
    tick();
    checks++;
    if (!ok || doneCnt - d0 != 1 || fsm !== 3'd0) begin
      errors++; $display("FAIL mid_next_frame: ok %b done %0d fsm %0d expected 1/1/0", ok, doneCnt - d0, fsm);
    end
  endtask

  task automatic test_one_stage();
    int rs0 = rdStartCnt, d0 = doneCnt;
    bit ok;
    dft_size = 4; num_stages = 3'd0;
    sinkFrame(4, 1'b0, 1'b0);
    runStages(1, ok);
    checks++;
    if (!ok || fsm !== 3'd5) begin errors++; $display("FAIL zero_stage_src: ok %b fsm %0d expected 1/5", ok, fsm); end
    runSource(1'b0, ok);
    tick();
    checks++;
    if (!ok || rdStartCnt - rs0 != 1 || doneCnt - d0 != 1) begin
      errors++;
      $display("FAIL zero_stage_counts: ok %b rd_start %0d done %0d expected 1/1/1",
               ok, rdStartCnt - rs0, doneCnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_len_err();
    test_overtime();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_one_stage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrd_fsm_ctrl.md
MRD_FSM_CTRL -- requirements
Module: mrd_fsm_ctrl

Interface
REQ-001 SHALL have parameter wCNT, default 12, the width of the frame-length and beat counters.
REQ-002 SHALL have parameter WAIT_CYC, default 4, the idle cycles inserted in Wait_to_rd before each read stage.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port dft_size, input, wCNT, the frame length N in beats; sampled on sop acceptance.
REQ-006 SHALL have port num_stages, input, 3, the number of butterfly stages; sampled on sop acceptance.
REQ-007 SHALL have port in_valid, input, 1, sink beat valid.
REQ-008 SHALL have port in_sop, input, 1, first beat of a frame.
REQ-009 SHALL have port in_eop, input, 1, last beat of a frame.
REQ-010 SHALL have port overTime, input, 1, sink watchdog expiry from the sink writer.
REQ-011 SHALL have port rd_last, input, 1, last read of the current stage from the datapath.
REQ-012 SHALL have port wr_last, input, 1, last write-back of the current stage.
REQ-013 SHALL have port src_ready, input, 1, downstream accept.
REQ-014 SHALL have port in_ready, output, 1, high in Idle and Sink.
REQ-015 SHALL have port fsm, output, 3, the current state code.
REQ-016 SHALL have port stage, output, 3, the current stage index.
REQ-017 SHALL have port rd_start, output, 1, one-cycle pulse on entry to Rd.
REQ-018 SHALL have port src_valid, output, 1, source beat valid.
REQ-019 SHALL have port src_last, output, 1, final source beat.
REQ-020 SHALL have port done, output, 1, one-cycle pulse when a frame completes.
REQ-021 SHALL have port err_overtime, output, 1, one-cycle pulse when Sink aborts on overTime.
REQ-022 SHALL have port err_len, output, 1, one-cycle pulse on a frame-length mismatch.

Function
REQ-023 SHALL use state codes Idle=0, Sink=1, Wait_to_rd=2, Rd=3, Wait_wr_end=4, Source=5; codes 6 and 7 SHALL return to Idle on the next cycle.
REQ-024 Idle: in_valid&in_sop SHALL go to Sink, latch dft_size and num_stages (0 treated as 1), and set beat count to 1.
REQ-025 Sink: each in_valid SHALL increment the beat count; in_sop inside Sink SHALL be ignored.
REQ-026 Sink: in_valid&in_eop with count==N SHALL go to Wait_to_rd with stage=0; with count!=N SHALL pulse err_len and go to Idle.
REQ-027 Sink: overTime SHALL take priority over eop in the same cycle, pulse err_overtime and go to Idle.
REQ-028 Wait_to_rd SHALL hold exactly WAIT_CYC cycles, then go to Rd, with rd_start high for the first Rd cycle.
REQ-029 Rd: rd_last SHALL go to Wait_wr_end; wr_last seen in Rd SHALL be ignored.
REQ-030 Wait_wr_end: wr_last with stage==num_stages-1 SHALL go to Source; otherwise stage SHALL increment and the state SHALL go to Wait_to_rd.
REQ-031 Source: src_valid SHALL be high throughout; each src_valid&src_ready SHALL advance a beat counter from 0.
REQ-032 src_last SHALL be asserted when the beat counter equals N-1; its acceptance SHALL pulse done and go to Idle.
REQ-033 Stalls in Source (src_ready low) SHALL hold the counter with src_valid still high.
REQ-034 in_valid outside Idle/Sink SHALL be ignored (in_ready low).
REQ-035 All outputs SHALL be registered; fsm SHALL reflect the new state one cycle after the triggering input.
REQ-036 Counters SHALL be wCNT bits with no wrap; count saturation at 2^wCNT-1 SHALL be treated as a length mismatch.

Reset
REQ-037 rst_n low SHALL asynchronously force fsm=Idle, stage=0, all counters=0, and every output low except in_ready, which SHALL be 1.
REQ-038 Reset mid-frame SHALL discard the frame; on release the block SHALL require a fresh sop.

Structure
REQ-039 State codes and WAIT_CYC default SHALL live in shared package mrd_pkg for use by the sink, read and source blocks.
REQ-040 SHALL be one module, no sub-modules; the next-state logic and the registers SHALL be separate processes.

Verification
REQ-041 N=12, num_stages=2, 12 beats sop..eop, rd_last and wr_last after 5 cycles each -> fsm sequence 1,2,3,4,2,3,4,5; two rd_start pulses; 12 source beats; done once.
REQ-042 N=12 with eop on beat 10 -> err_len pulse, fsm=0, no rd_start.
REQ-043 overTime and eop in the same Sink cycle -> err_overtime only, fsm=0.
REQ-044 Source with src_ready toggling 1,0 -> 12 accepted beats, src_last only on beat 11, done 1 cycle after its acceptance.
REQ-045 rst_n low during Rd, stage=1 -> immediately fsm=0, stage=0, in_ready=1; next frame runs normally.
REQ-046 num_stages=0 -> behaves as 1 stage: exactly one rd_start per frame.
